// File: rtl/fifo_uart_pkg.sv
// fifo_uart_pkg: shared types and constants for the FIFO_OUT -> UART drain stage.
package fifo_uart_pkg;

   // Explicit encodings keep state values identical to the legacy netlist.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_e;

   localparam int unsigned UART_DATA_BITS = 8;
   localparam int unsigned BYTES_PER_WORD = 4;

   // Even parity bit for one data byte.
   function automatic logic byte_parity(input logic [7:0] b);
      return ^b;
   endfunction

endpackage

// File: rtl/fifo2_uart_tx_timer.sv
// uart_bit_timer: raises tick once every CLKS_PER_BIT enabled cycles.
// load restarts the count at 0; the counter is held at 0 while disabled.
module uart_bit_timer #(
   parameter int unsigned CLKS_PER_BIT = 434
) (
   input  logic clk,
   input  logic rst,
   input  logic load_i,
   input  logic en_i,
   output logic tick_o
);

   localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

   logic [15:0] cnt_q, cnt_d;

   // Next count: clear on load/disable, wrap at the last cycle of a bit.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i || !en_i) begin
         cnt_d = '0;
      end else if (cnt_q == LAST) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   // Counter register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/fifo2_uart_tx.sv
// fifo2_uart_tx: pops 32-bit words from FIFO_OUT while start is high and
// sends each as four UART bytes, LSB byte first.
// Build option: define FIFO2_UART_PARITY_EN for 8E1 framing (default 8N1).
module fifo2_uart_tx
   import fifo_uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 434
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        fifo_empty,
   input  logic [31:0] fifo_rd_data,
   output logic        fifo_rd_en,
   output logic        uart_txd,
   output logic        busy,
   output logic [15:0] words_sent
);

   tx_state_e   state_q, state_d;
   logic [31:0] word_q, word_d;
   logic [1:0]  byte_idx_q, byte_idx_d;
   logic [2:0]  bit_idx_q, bit_idx_d;
   logic        txd_q, txd_d;
   logic [15:0] ws_q, ws_d;
   logic        pop;
   logic        tick;

   // Pop is gated by reset so no word is consumed while the block is held.
   assign pop = rst && (state_q == ST_IDLE) && start && !fifo_empty;

   uart_bit_timer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_timer (
      .clk   (clk),
      .rst   (rst),
      .load_i(pop),
      .en_i  (state_q != ST_IDLE),
      .tick_o(tick)
   );

   // Frame sequencing; the line level is derived from the next state so
   // uart_txd can be registered without adding a cycle of latency.
   always_comb begin
      state_d    = state_q;
      word_d     = word_q;
      byte_idx_d = byte_idx_q;
      bit_idx_d  = bit_idx_q;
      ws_d       = ws_q;
      case (state_q)
         ST_IDLE: begin
            if (pop) begin
               word_d     = fifo_rd_data;
               byte_idx_d = '0;
               state_d    = ST_START;
            end
         end
         ST_START: begin
            if (tick) begin
               bit_idx_d = '0;
               state_d   = ST_DATA;
            end
         end
         ST_DATA: begin
            if (tick) begin
               if (bit_idx_q == 3'(UART_DATA_BITS - 1)) begin
`ifdef FIFO2_UART_PARITY_EN
                  state_d = ST_PARITY;
`else
                  state_d = ST_STOP;
`endif
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end
         end
`ifdef FIFO2_UART_PARITY_EN
         ST_PARITY: begin
            if (tick) begin
               state_d = ST_STOP;
            end
         end
`endif
         ST_STOP: begin
            if (tick) begin
               if (byte_idx_q == 2'(BYTES_PER_WORD - 1)) begin
                  ws_d    = ws_q + 16'd1;
                  state_d = ST_IDLE;
               end else begin
                  byte_idx_d = byte_idx_q + 2'd1;
                  state_d    = ST_START;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      case (state_d)
         ST_START: txd_d = 1'b0;
         ST_DATA:  txd_d = word_d[{byte_idx_d, bit_idx_d}];
`ifdef FIFO2_UART_PARITY_EN
         ST_PARITY: txd_d = byte_parity(word_d[{byte_idx_d, 3'b000} +: 8]);
`endif
         default:  txd_d = 1'b1;
      endcase
   end

   // State registers; reset abandons any word in flight and idles the line.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         word_q     <= '0;
         byte_idx_q <= '0;
         bit_idx_q  <= '0;
         txd_q      <= 1'b1;
         ws_q       <= '0;
      end else begin
         state_q    <= state_d;
         word_q     <= word_d;
         byte_idx_q <= byte_idx_d;
         bit_idx_q  <= bit_idx_d;
         txd_q      <= txd_d;
         ws_q       <= ws_d;
      end
   end

   assign fifo_rd_en = pop;
   assign uart_txd   = txd_q;
   assign busy       = (state_q != ST_IDLE);
   assign words_sent = ws_q;

endmodule

// File: doc/fifo2_uart_tx.md
# fifo2_uart_tx

Drain stage for the TRNG output FIFO (FIFO_OUT): pops 32-bit words written there by the PicoRV32 memory-mapped bus bridge and serialises each word as four UART 8N1 bytes, least-significant byte first. Sits directly downstream of FIFO_OUT and gates on the bridge's `loading_out` control flag, which the top level wires to `start`. It is the only path by which random words leave the FPGA.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per UART bit (50 MHz / 115200); legal range 2..65535.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset: synchronous, active-low (0 = reset).
- `start`  in  1  level enable; words are popped only while high.
- `fifo_empty`  in  1  FIFO_OUT empty flag.
- `fifo_rd_data`  in  32  FIFO_OUT head word; first-word-fall-through, valid whenever `fifo_empty`=0.
- `fifo_rd_en`  out  1  one-cycle pop strobe.
- `uart_txd`  out  1  serial line, idle high.
- `busy`  out  1  high from pop until the last stop bit of the word ends.
- `words_sent`  out  16  count of completed words, wraps.

## Operation
- Reset values: `fifo_rd_en`=0, `uart_txd`=1, `busy`=0, `words_sent`=0, FSM in IDLE, bit timer and indices cleared.
- FSM states: IDLE, START, DATA, (PARITY), STOP.
- IDLE: if `start`=1 and `fifo_empty`=0, latch `fifo_rd_data` into the 32-bit shift word, pulse `fifo_rd_en` for exactly that cycle, set byte_idx=0 and `busy`=1, and go to START. Otherwise stay.
- START: `uart_txd`=0 for CLKS_PER_BIT cycles, then DATA with bit_idx=0.
- DATA: drive bit bit_idx of byte byte_idx (word bits [8*byte_idx+bit_idx]) for CLKS_PER_BIT cycles each. After bit 7 go to PARITY if enabled, else STOP.
- STOP: `uart_txd`=1 for CLKS_PER_BIT cycles. Then:
  - if byte_idx<3: byte_idx+1 and go to START;
  - if byte_idx=3: `words_sent`+1 (modulo 2^16), `busy`=0, go to IDLE.
- `start` falling mid-word has no effect on the current word; it completes all 4 bytes, and no further pop occurs.
- `fifo_rd_en` is never asserted while `fifo_empty`=1 or outside IDLE.
- Reset asserted mid-frame: the word is abandoned (not counted), and `uart_txd` returns to 1 on the same edge.

## Timing
- Pop cycle to start-bit falling edge: 1 cycle (`uart_txd` registered).
- Byte frame: 10×CLKS_PER_BIT cycles (11× with parity).
- Word: 40×CLKS_PER_BIT cycles, plus 1 IDLE cycle before the next pop, so back-to-back words have a minimum pop-to-pop period of 40×CLKS_PER_BIT+1.
- `words_sent` updates on the cycle STOP of byte 3 ends; `busy` falls on the same edge.
- Bit timer counts 0..CLKS_PER_BIT-1 and is reloaded on every state or bit change. No fractional-baud accumulation.

## Configuration
- `FIFO2_UART_PARITY_EN` defined: each byte is sent 8E1. After DATA, the PARITY state drives the XOR of the byte's 8 bits for CLKS_PER_BIT cycles.
- Not defined: 8N1 and the PARITY state is absent.

## Structure
- Package `fifo_uart_pkg`: FSM state enum, `UART_DATA_BITS`=8, `BYTES_PER_WORD`=4, and a parity function.
- One sub-module, `uart_bit_timer`, which takes a load strobe and raises `tick` once every CLKS_PER_BIT cycles. The FSM, shift word and counters live in `fifo2_uart_tx`.

## Test plan
All scenarios use CLKS_PER_BIT=4 unless stated.

- Reset: hold `rst`=0 for 3 cycles with `start`=1 and FIFO non-empty -> `uart_txd`=1, `fifo_rd_en`=0, `words_sent`=0.
- Single word: `start`=1, FIFO holds 0xA55A0F31 -> exactly one pop pulse; line decodes bytes 0x31, 0x0F, 0x5A, 0xA5 with every bit 4 cycles wide; `words_sent`=1; `busy` high for 160 cycles.
- Back-to-back: FIFO holds 0x00000000 and 0xFFFFFFFF -> second pop exactly 161 cycles after the first; decoded bytes 00×4 then FF×4.
- Gating: FIFO non-empty and `start`=0 for 100 cycles -> no pop, line stays high. `start` dropped at byte 1 -> word completes, with no second pop.
- Reset mid-frame: `rst`=0 during DATA of byte 2 -> `uart_txd`=1 next edge, `words_sent` unchanged at 0. After release, the next word is transmitted from byte 0.
- Parity build (macro defined): word 0x00000307 -> bytes 0x07 and 0x03 carry parity 1 and 0, bytes 0x00 carry 0; frame is 44 cycles per byte. Also, 65536 words -> `words_sent` wraps to 0.
